// File: rtl/cpu_pkg.sv
// -----------------------------------------------------------------------------
// cpu_pkg
// Definitions shared by the single-cycle CPU core:
//   - opcode constants for the instruction set (OP_LOADI .. OP_MUL)
//   - seq_state_t, the state type of the PC sequencer
//   - bit positions of the signed word branch offset inside an instruction
// -----------------------------------------------------------------------------
package cpu_pkg;

   localparam logic [7:0] OP_LOADI = 8'h00;
   localparam logic [7:0] OP_MOV   = 8'h01;
   localparam logic [7:0] OP_ADD   = 8'h02;
   localparam logic [7:0] OP_SUB   = 8'h03;
   localparam logic [7:0] OP_AND   = 8'h04;
   localparam logic [7:0] OP_OR    = 8'h05;
   localparam logic [7:0] OP_J     = 8'h06;
   localparam logic [7:0] OP_BEQ   = 8'h07;
   localparam logic [7:0] OP_LWD   = 8'h08;
   localparam logic [7:0] OP_LWI   = 8'h09;
   localparam logic [7:0] OP_SWD   = 8'h0A;
   localparam logic [7:0] OP_SWI   = 8'h0B;
   localparam logic [7:0] OP_BNE   = 8'h0C;
   localparam logic [7:0] OP_MUL   = 8'h0D;

   localparam int INSTR_OPCODE_MSB = 31;
   localparam int INSTR_OPCODE_LSB = 24;
   localparam int INSTR_OFFSET_MSB = 23;
   localparam int INSTR_OFFSET_LSB = 16;

   typedef enum logic [1:0] {
      BOOT     = 2'd0,
      RUN      = 2'd1,
      MUL_WAIT = 2'd2
   } seq_state_t;

endpackage : cpu_pkg

// File: rtl/sat_counter.sv
// -----------------------------------------------------------------------------
// sat_counter
// Up-counter that sticks at its all-ones value instead of wrapping.
// Ports:
//   CLK    in   clock, counts on the rising edge
//   RESET  in   asynchronous active-high clear
//   inc    in   count enable for this edge
//   count  out  current count (W bits)
// -----------------------------------------------------------------------------
module sat_counter #(
   parameter int W = 16
) (
   input  logic         CLK,
   input  logic         RESET,
   input  logic         inc,
   output logic [W-1:0] count
);

   localparam logic [W-1:0] ONE = {{(W-1){1'b0}}, 1'b1};

   logic [W-1:0] count_q;

   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         count_q <= '0;
      end else if (inc && (count_q != {W{1'b1}})) begin
         count_q <= count_q + ONE;
      end
   end

   assign count = count_q;

endmodule : sat_counter

// File: rtl/pc_sequencer.sv
// -----------------------------------------------------------------------------
// pc_sequencer
// Owns the program counter of the single-cycle core and decides each cycle
// whether the current instruction completes ("done") or the core stalls.
// Multiplies take MUL_CYCLES cycles; memory BUSYWAIT freezes everything.
// Ports:
//   CLK, RESET        clock / asynchronous active-high reset
//   INSTRUCTION[31:0] current instruction ([31:24] opcode, [23:16] offset)
//   branch, jump,     branch decodes from the control unit
//   b_notequal
//   ZERO              ALU result equals zero
//   BUSYWAIT          memory stall request
//   WRITEENABLE       raw register-file write enable
//   PC[31:0]          address of the current instruction
//   REG_WRITE         write enable gated so each instruction writes once
//   STALL             PC will not advance at the next edge
//   INSTR_COUNT       retired instructions (saturating)
//   STALL_COUNT       stall cycles outside BOOT (saturating)
// -----------------------------------------------------------------------------
module pc_sequencer
   import cpu_pkg::*;
#(
   parameter logic [31:0] RESET_PC   = 32'd0,
   parameter int          MUL_CYCLES = 4,
   parameter int          CNT_W      = 16
) (
   input  logic             CLK,
   input  logic             RESET,
   input  logic [31:0]      INSTRUCTION,
   input  logic             branch,
   input  logic             jump,
   input  logic             b_notequal,
   input  logic             ZERO,
   input  logic             BUSYWAIT,
   input  logic             WRITEENABLE,
   output logic [31:0]      PC,
   output logic             REG_WRITE,
   output logic             STALL,
   output logic [CNT_W-1:0] INSTR_COUNT,
   output logic [CNT_W-1:0] STALL_COUNT
);

   // Counter reload on mul entry: the RUN cycle already counts as one.
   localparam logic [3:0] MUL_LOAD   = 4'(MUL_CYCLES - 1);
   localparam bit         SINGLE_MUL = (MUL_CYCLES == 1);

   seq_state_t  state_q;
   logic [31:0] pc_q;
   logic [3:0]  mul_cnt_q;

   logic [7:0]  opcode;
   logic [7:0]  offset;
   logic [31:0] offset_ext;
   logic        take_d;
   logic        done_d;
   logic [31:0] pc_d;
   logic        stall_inc_d;

   // Low instruction bits belong to the datapath, not to sequencing.
   logic        unused_instr;
   assign unused_instr = ^INSTRUCTION[15:0];

   assign opcode     = INSTRUCTION[INSTR_OPCODE_MSB:INSTR_OPCODE_LSB];
   assign offset     = INSTRUCTION[INSTR_OFFSET_MSB:INSTR_OFFSET_LSB];
   // Word offset: sign-extend and scale by 4.
   assign offset_ext = {{22{offset[7]}}, offset, 2'b00};

   always_comb begin
      done_d = 1'b0;
      case (state_q)
         RUN:      done_d = ~BUSYWAIT & ((opcode != OP_MUL) | SINGLE_MUL);
         MUL_WAIT: done_d = ~BUSYWAIT & (mul_cnt_q == 4'd1);
         default:  done_d = 1'b0;
      endcase
   end

   // ZERO only matters when one of the conditional branches is decoded.
   assign take_d = jump | (branch & ZERO) | (b_notequal & ~ZERO);
   assign pc_d   = take_d ? (pc_q + 32'd4 + offset_ext) : (pc_q + 32'd4);

   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         state_q   <= BOOT;
         pc_q      <= RESET_PC;
         mul_cnt_q <= 4'd0;
      end else if (!BUSYWAIT) begin
         case (state_q)
            BOOT: begin
               state_q <= RUN;
            end
            RUN: begin
               if (done_d) begin
                  pc_q <= pc_d;
               end else begin
                  // Only a multi-cycle mul can leave RUN without completing.
                  mul_cnt_q <= MUL_LOAD;
                  state_q   <= MUL_WAIT;
               end
            end
            MUL_WAIT: begin
               if (mul_cnt_q == 4'd1) begin
                  pc_q      <= pc_d;
                  mul_cnt_q <= 4'd0;
                  state_q   <= RUN;
               end else begin
                  mul_cnt_q <= mul_cnt_q - 4'd1;
               end
            end
            default: begin
               state_q <= BOOT;
            end
         endcase
      end
   end

   assign PC          = pc_q;
   assign REG_WRITE   = WRITEENABLE & done_d;
   assign STALL       = ~done_d;
   // BOOT is a fixed decode bubble, not a stall worth reporting.
   assign stall_inc_d = ~done_d & (state_q != BOOT);

   sat_counter #(.W(CNT_W)) u_instr_cnt (
      .CLK   (CLK),
      .RESET (RESET),
      .inc   (done_d),
      .count (INSTR_COUNT)
   );

   sat_counter #(.W(CNT_W)) u_stall_cnt (
      .CLK   (CLK),
      .RESET (RESET),
      .inc   (stall_inc_d),
      .count (STALL_COUNT)
   );

endmodule : pc_sequencer

// File: tb/tb_pc_sequencer.sv
module tb_pc_sequencer;
   import cpu_pkg::*;

   logic        CLK = 1'b0;
   logic        RESET;
   logic [31:0] INSTRUCTION;
   logic        branch, jump, b_notequal, ZERO, BUSYWAIT, WRITEENABLE;

   logic [31:0] PC,  PC2;
   logic        REG_WRITE, REG_WRITE2, STALL, STALL2;
   logic [15:0] INSTR_COUNT, STALL_COUNT, INSTR_COUNT2, STALL_COUNT2;

   int checks = 0;
   int errors = 0;

   pc_sequencer #(.RESET_PC(32'd0), .MUL_CYCLES(4), .CNT_W(16)) dut (
      .CLK(CLK), .RESET(RESET), .INSTRUCTION(INSTRUCTION),
      .branch(branch), .jump(jump), .b_notequal(b_notequal), .ZERO(ZERO),
      .BUSYWAIT(BUSYWAIT), .WRITEENABLE(WRITEENABLE),
      .PC(PC), .REG_WRITE(REG_WRITE), .STALL(STALL),
      .INSTR_COUNT(INSTR_COUNT), .STALL_COUNT(STALL_COUNT)
   );

   // Same stimulus, PC starting just below the 2^32 wrap point.
   pc_sequencer #(.RESET_PC(32'hFFFF_FFFC), .MUL_CYCLES(4), .CNT_W(16)) dut_wrap (
      .CLK(CLK), .RESET(RESET), .INSTRUCTION(INSTRUCTION),
      .branch(branch), .jump(jump), .b_notequal(b_notequal), .ZERO(ZERO),
      .BUSYWAIT(BUSYWAIT), .WRITEENABLE(WRITEENABLE),
      .PC(PC2), .REG_WRITE(REG_WRITE2), .STALL(STALL2),
      .INSTR_COUNT(INSTR_COUNT2), .STALL_COUNT(STALL_COUNT2)
   );

   always #5 CLK = ~CLK;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic drive(input logic [7:0] op, input logic [7:0] off,
                        input logic br, input logic jp, input logic bn,
                        input logic z, input logic bw, input logic we);
      INSTRUCTION = {op, off, 16'h0000};
      branch      = br;
      jump        = jp;
      b_notequal  = bn;
      ZERO        = z;
      BUSYWAIT    = bw;
      WRITEENABLE = we;
   endtask

   // Check the cycle's combinational outputs mid-cycle, then advance one edge.
   task automatic cyc(input string tag, input logic [31:0] pc, input logic rw, input logic st);
      @(negedge CLK);
      chk({tag, "_pc"}, PC, pc);
      chk({tag, "_rw"}, {31'd0, REG_WRITE}, {31'd0, rw});
      chk({tag, "_st"}, {31'd0, STALL}, {31'd0, st});
      @(posedge CLK);
      #1;
   endtask

   initial begin
      RESET = 1'b1;
      drive(OP_ADD, 8'h00, 0, 0, 0, 0, 0, 1);
      #3;
      chk("rst_pc",    PC, 32'd0);
      chk("rst_rw",    {31'd0, REG_WRITE}, 32'd0);
      chk("rst_st",    {31'd0, STALL}, 32'd1);
      chk("rst_icnt",  {16'd0, INSTR_COUNT}, 32'd0);
      chk("rst_scnt",  {16'd0, STALL_COUNT}, 32'd0);
      @(posedge CLK); #1;
      RESET = 1'b0;

      // BOOT bubble then three adds
      cyc("boot", 32'd0, 1'b0, 1'b1);
      cyc("add0", 32'd0, 1'b1, 1'b0);
      cyc("add1", 32'd4, 1'b1, 1'b0);
      cyc("add2", 32'd8, 1'b1, 1'b0);
      chk("add_pc",   PC, 32'd12);
      chk("add_icnt", {16'd0, INSTR_COUNT}, 32'd3);
      chk("add_scnt", {16'd0, STALL_COUNT}, 32'd0);

      // 12 + 4 - 8 = 8
      drive(OP_J, 8'hFE, 0, 1, 0, 0, 0, 0);
      cyc("j1", 32'd12, 1'b0, 1'b0);
      drive(OP_BEQ, 8'hFE, 1, 0, 0, 1, 0, 0);
      cyc("beq_t", 32'd8, 1'b0, 1'b0);
      chk("beq_t_npc", PC, 32'd4);
      // ZERO high without any branch decode must not redirect
      drive(OP_ADD, 8'hFE, 0, 0, 0, 1, 0, 1);
      cyc("add_z", 32'd4, 1'b1, 1'b0);
      drive(OP_BEQ, 8'hFE, 1, 0, 0, 0, 0, 0);
      cyc("beq_nt", 32'd8, 1'b0, 1'b0);
      chk("beq_nt_npc", PC, 32'd12);
      drive(OP_J, 8'hFE, 0, 1, 0, 0, 0, 0);
      cyc("j2", 32'd12, 1'b0, 1'b0);
      drive(OP_BNE, 8'h02, 0, 0, 1, 0, 0, 0);
      cyc("bne", 32'd8, 1'b0, 1'b0);
      chk("bne_npc", PC, 32'd20);
      drive(OP_J, 8'hFE, 0, 1, 0, 0, 0, 0);
      cyc("j3", 32'd20, 1'b0, 1'b0);

      // mul at 16: three stall cycles, write on the fourth
      drive(OP_MUL, 8'h00, 0, 0, 0, 0, 0, 1);
      cyc("mul_a", 32'd16, 1'b0, 1'b1);
      cyc("mul_b", 32'd16, 1'b0, 1'b1);
      cyc("mul_c", 32'd16, 1'b0, 1'b1);
      cyc("mul_d", 32'd16, 1'b1, 1'b0);
      chk("mul_npc",  PC, 32'd20);
      chk("mul_scnt", {16'd0, STALL_COUNT}, 32'd3);

      drive(OP_LOADI, 8'h00, 0, 0, 0, 0, 0, 1);
      cyc("ldi", 32'd20, 1'b1, 1'b0);
      drive(OP_LOADI, 8'h00, 0, 0, 0, 0, 1, 1);
      for (int i = 0; i < 5; i++) cyc("bw", 32'd24, 1'b0, 1'b1);
      drive(OP_LOADI, 8'h00, 0, 0, 0, 0, 0, 1);
      cyc("bw_rel", 32'd24, 1'b1, 1'b0);
      chk("bw_npc",  PC, 32'd28);
      chk("bw_icnt", {16'd0, INSTR_COUNT}, 32'd13);
      chk("bw_scnt", {16'd0, STALL_COUNT}, 32'd8);

      // 28 + 4 + 8 = 40
      drive(OP_J, 8'h02, 0, 1, 0, 0, 0, 0);
      cyc("j4", 32'd28, 1'b0, 1'b0);
      drive(OP_MUL, 8'h00, 0, 0, 0, 0, 0, 1);
      cyc("mul40", 32'd40, 1'b0, 1'b1);
      // now in MUL_WAIT; reset between clock edges
      #2 RESET = 1'b1;
      #1;
      chk("arst_pc",   PC, 32'd0);
      chk("arst_rw",   {31'd0, REG_WRITE}, 32'd0);
      chk("arst_st",   {31'd0, STALL}, 32'd1);
      chk("arst_icnt", {16'd0, INSTR_COUNT}, 32'd0);
      chk("arst_scnt", {16'd0, STALL_COUNT}, 32'd0);
      @(posedge CLK); #1;
      RESET = 1'b0;
      cyc("boot2", 32'd0, 1'b0, 1'b1);

      // BUSYWAIT arrives exactly when the mul would finish
      cyc("m2a", 32'd0, 1'b0, 1'b1);
      cyc("m2b", 32'd0, 1'b0, 1'b1);
      cyc("m2c", 32'd0, 1'b0, 1'b1);
      drive(OP_MUL, 8'h00, 0, 0, 0, 0, 1, 1);
      cyc("m2bw0", 32'd0, 1'b0, 1'b1);
      cyc("m2bw1", 32'd0, 1'b0, 1'b1);
      drive(OP_MUL, 8'h00, 0, 0, 0, 0, 0, 1);
      cyc("m2d", 32'd0, 1'b1, 1'b0);
      chk("m2_npc",  PC, 32'd4);
      chk("m2_icnt", {16'd0, INSTR_COUNT}, 32'd1);
      chk("m2_scnt", {16'd0, STALL_COUNT}, 32'd5);

      // stall counter saturation
      RESET = 1'b1;
      @(posedge CLK); #1;
      RESET = 1'b0;
      drive(8'hFF, 8'h00, 0, 0, 0, 0, 0, 0);
      cyc("boot3", 32'd0, 1'b0, 1'b1);
      drive(8'hFF, 8'h00, 0, 0, 0, 0, 1, 0);
      repeat (65534) @(posedge CLK);
      #1;
      chk("sat_fffe", {16'd0, STALL_COUNT}, 32'h0000_FFFE);
      chk("sat_pc",   PC, 32'd0);
      repeat (3) @(posedge CLK);
      #1;
      chk("sat_ffff", {16'd0, STALL_COUNT}, 32'h0000_FFFF);
      chk("sat_icnt", {16'd0, INSTR_COUNT}, 32'd0);

      // jump with zero offset across the 2^32 boundary
      chk("wrap_pc0", PC2, 32'hFFFF_FFFC);
      drive(OP_J, 8'h00, 0, 1, 0, 0, 0, 0);
      @(posedge CLK); #1;
      chk("wrap_pc",  PC2, 32'd0);
      chk("wrap_ref", PC, 32'd4);
      chk("sat_hold", {16'd0, STALL_COUNT}, 32'h0000_FFFF);

      // unknown opcode falls through
      drive(8'hFF, 8'h7F, 0, 0, 0, 1, 0, 0);
      cyc("unk", 32'd4, 1'b0, 1'b0);
      chk("unk_npc",  PC, 32'd8);
      chk("unk_icnt", {16'd0, INSTR_COUNT}, 32'd2);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule : tb_pc_sequencer
